// File: rtl/ir_decoder.sv
// ir_decoder: receiver for the 36 kHz IR command link.
// Recovers 32-bit pulse-distance coded command words (LSB first) from raw
// carrier or a demodulated envelope and presents them on a valid/ready port.
// Bit 31 of every frame is unrecoverable on the line and is always reported 0.
// Optional feature macro: IR_DECODER_ACTIVE_LOW_EN (inverts ir_input for
// TSOP-style demodulators whose output is low during a mark).
module ir_decoder #(
    parameter int unsigned CLK_FREQ    = 25_000_000,
    parameter int unsigned START_TICKS = 112_500,
    parameter int unsigned BIT_TICKS   = 13_888,
    parameter int unsigned HOLD_TICKS  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_input,
    output logic [31:0] cmd,
    output logic        valid,
    input  logic        ready,
    output logic        err,
    output logic        overrun
);

    localparam int unsigned DUR_W         = 20;
    localparam int unsigned HOLD_W        = $clog2(HOLD_TICKS + 1);
    localparam int unsigned CARRIER_HZ    = 36_000;
    localparam int unsigned CARRIER_TICKS = CLK_FREQ / CARRIER_HZ;
    localparam int unsigned ONE_TICKS     = 3 * BIT_TICKS;

    // Acceptance windows: nominal +/- 25 %
    localparam logic [DUR_W-1:0] START_LO = DUR_W'(START_TICKS - (START_TICKS >> 2));
    localparam logic [DUR_W-1:0] START_HI = DUR_W'(START_TICKS + (START_TICKS >> 2));
    localparam logic [DUR_W-1:0] BIT_LO   = DUR_W'(BIT_TICKS - (BIT_TICKS >> 2));
    localparam logic [DUR_W-1:0] BIT_HI   = DUR_W'(BIT_TICKS + (BIT_TICKS >> 2));
    localparam logic [DUR_W-1:0] ONE_LO   = DUR_W'(ONE_TICKS - (ONE_TICKS >> 2));
    localparam logic [DUR_W-1:0] ONE_HI   = DUR_W'(ONE_TICKS + (ONE_TICKS >> 2));
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;

    // The envelope hold must bridge carrier gaps yet stay short against a bit
    if (HOLD_TICKS <= CARRIER_TICKS) begin : g_hold_too_short
        $error("ir_decoder: HOLD_TICKS must exceed the carrier period");
    end
    if (4 * HOLD_TICKS >= BIT_TICKS) begin : g_hold_too_long
        $error("ir_decoder: HOLD_TICKS must be below BIT_TICKS/4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_MARK,
        S_START_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE
    } state_t;

    logic              ir_raw_c;
    logic [1:0]        sync;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              env;
    logic              env_prev;
    logic              rise_c;
    logic              fall_c;
    logic [DUR_W-1:0]  dur;
    logic [DUR_W-1:0]  limit_c;
    logic              timeout_c;
    state_t            state;
    logic [4:0]        bit_cnt;
    logic [30:0]       shreg;

`ifdef IR_DECODER_ACTIVE_LOW_EN
    assign ir_raw_c = ~ir_input;
`else
    assign ir_raw_c = ir_input;
`endif

    function automatic logic in_win(input logic [DUR_W-1:0] d,
                                    input logic [DUR_W-1:0] lo,
                                    input logic [DUR_W-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // Hold counter next value: reload on any high sample, else count down to 0
    always_comb begin
        hold_next = hold_cnt;
        if (sync[1]) begin
            hold_next = HOLD_W'(HOLD_TICKS);
        end else if (hold_cnt != '0) begin
            hold_next = hold_cnt - HOLD_W'(1);
        end
    end

    // Synchronizer, envelope hold and registered envelope with its delayed copy
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            hold_cnt <= '0;
            env      <= 1'b0;
            env_prev <= 1'b0;
        end else begin
            sync     <= {sync[0], ir_raw_c};
            hold_cnt <= hold_next;
            env      <= (hold_next != '0);
            env_prev <= env;
        end
    end

    assign rise_c = env & ~env_prev;
    assign fall_c = ~env & env_prev;

    // Duration of the current envelope level, restarted on every edge
    always_ff @(posedge clk) begin
        if (rst) begin
            dur <= '0;
        end else if (rise_c || fall_c) begin
            dur <= '0;
        end else if (dur != DUR_MAX) begin
            dur <= dur + DUR_W'(1);
        end
    end

    // Longest legal duration in each state; exceeding it aborts without an edge
    always_comb begin
        limit_c = DUR_MAX;
        case (state)
            S_START_MARK,
            S_START_SPACE: limit_c = START_HI;
            S_BIT_MARK:    limit_c = BIT_HI;
            S_BIT_SPACE:   limit_c = ONE_HI;
            default:       limit_c = DUR_MAX;
        endcase
    end

    assign timeout_c = (state != S_IDLE) && (dur > limit_c);

    // Frame FSM, bit assembly and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            cmd     <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            err     <= 1'b0;
            overrun <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (rise_c) begin
                        state <= S_START_MARK;
                    end
                end
                S_START_MARK: begin
                    if (fall_c) begin
                        if (in_win(dur, START_LO, START_HI)) begin
                            state <= S_START_SPACE;
                        end else begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else if (timeout_c) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_START_SPACE: begin
                    if (rise_c) begin
                        if (in_win(dur, START_LO, START_HI)) begin
                            bit_cnt <= '0;
                            shreg   <= '0;
                            state   <= S_BIT_MARK;
                        end else begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else if (timeout_c) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_BIT_MARK: begin
                    if (fall_c) begin
                        if (!in_win(dur, BIT_LO, BIT_HI)) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else if (bit_cnt == 5'd31) begin
                            // Last mark: its space merges into the inter-frame gap
                            state <= S_IDLE;
                            if (!valid || ready) begin
                                cmd   <= {1'b0, shreg};
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            state <= S_BIT_SPACE;
                        end
                    end else if (timeout_c) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_BIT_SPACE: begin
                    if (rise_c) begin
                        if (in_win(dur, BIT_LO, BIT_HI)) begin
                            shreg   <= {1'b0, shreg[30:1]};
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= S_BIT_MARK;
                        end else if (in_win(dur, ONE_LO, ONE_HI)) begin
                            shreg   <= {1'b1, shreg[30:1]};
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= S_BIT_MARK;
                        end else begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else if (timeout_c) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
